instruction_decode: RTL
=======================

# instruction_decode

Decode stage of the five-stage RV32I pipeline: consumes the IF/ID pipeline register (instruction, PC, PC+4), decodes control, and reads operands from the 32×32 register file. It also generates the sign-extended immediate and drives the ID/EX pipeline register into execute. It also owns the register file's writeback port from the W stage. Supports FlushE so the hazard unit can insert bubbles.

## Interface
Parameters: none (fixed RV32I, XLEN 32).
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- IF_ID_IR  in  32  instruction from fetch
- IF_ID_PC  in  32  PC of that instruction
- IF_ID_PC4  in  32  PC+4 of that instruction
- FlushE  in  1  synchronous: load bubble into ID/EX this edge
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  4  ALU op code
- Funct3E  out  3  funct3, used for branch condition / load-store size
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  sign-extended immediate
- PCE, PCPlus4E  out  32  forwarded PC values
- Rs1E, Rs2E, RdE  out  5  register indices for forwarding/hazard logic

## Operation
- Decode by opcode = IR[6:0]: 0110011 R; 0010011 I-ALU; 0000011 load; 0100011 store; 1100011 branch; 1101111 jal; 1100111 jalr; 0110111 lui. Any other opcode (including 0x00000000) decodes as NOP: all enables and Branch/Jump/Jalr 0.
- Immediates: I = {20{IR[31]},IR[31:20]}; S = {20{IR[31]},IR[31:25],IR[11:7]}; B = {19{IR[31]},IR[31],IR[7],IR[30:25],IR[11:8],0}; J = {11{IR[31]},IR[31],IR[19:12],IR[20],IR[30:21],0}; U = {IR[31:12],12'b0}.
- ALUControl: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass-B.
  - R-type: from funct3 plus IR[30] (sub/sra).
  - I-ALU: IR[30] honoured only for srai (funct3 101); addi with IR[30]=1 is add.
  - load, store, jalr: add.
  - branch: sub.
  - lui: pass-B.
- ALUSrc = 1 for I-ALU, load, store, jalr, lui. ResultSrc 01 for load, 10 for jal/jalr. RegWrite for R, I-ALU, load, jal, jalr, lui.
- Register file:
  - x0 reads 0 always; writes to x0 ignored.
  - Write occurs on rising edge when RegWriteW=1 and RdW≠0.
  - Same-cycle read of RdW (≠0) while RegWriteW=1 returns ResultW (internal bypass).
- ID/EX register:
  - Captures all E outputs each rising edge.
  - FlushE=1: all control outputs (RegWrite, MemWrite, Branch, Jump, Jalr, ALUSrc, ResultSrc, ALUControl) load 0, and RdE/Rs1E/Rs2E load 0. Data fields may load normally.
  - FlushE does not block the register-file write in the same cycle.

## Timing
- rst asserted: every E output is 0 immediately (asynchronous) and stays 0 while asserted. All 31 registers x1–x31 clear to 0.
- Latency: IF_ID_* sampled → E outputs valid one clock later.
- Register-file write is visible combinationally via bypass in the write cycle and from storage thereafter.
- Reset mid-stream discards the in-flight ID/EX contents. The first edge after deassertion loads the current IF_ID_* contents.
- Control decode, immediate generation and operand read are purely combinational from IF_ID_IR within one cycle.

## Test plan
- Reset: assert rst with IF_ID_IR=0x00500093 → all E outputs 0, RD1E=0; deassert, one edge → RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=0000.
- Writeback and bypass:
  - RegWriteW=1, RdW=3, ResultW=0xDEADBEEF while IF_ID_IR=add x4,x3,x3 (0x00318233) → next edge RD1E=RD2E=0xDEADBEEF, ALUControlE=0000.
  - Same with RdW=0 → RD1E of add x4,x0,x0 = 0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) → ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0.
  - beq x0,x0,-8 (0xFE000CE3) → ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=0001.
  - jal x1,2048 (0x001000EF) → ImmExtE=0x00000800, JumpE=1, ResultSrcE=10.
- Decode corner cases:
  - srai x5,x5,3 (0x4032D293) → ALUControlE=1001.
  - lui x6,0x12345 (0x12345337) → ImmExtE=0x12345000, ALUControlE=1010.
  - Unknown opcode 0xFFFFFFFF → all controls 0.
- Flush: FlushE=1 with lw x7,8(x2) → RegWriteE=0, ResultSrcE=00, RdE=0; a register write from the W stage in that same cycle still lands and reads back on the following decode.

Source files
------------

// File: rtl/instruction_decode_if.sv
// instruction_decode_if: IF/ID inputs, W-stage writeback and ID/EX outputs of the decode stage
interface instruction_decode_if;
    logic [31:0] IF_ID_IR, IF_ID_PC, IF_ID_PC4;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    modport master (
        output IF_ID_IR, IF_ID_PC, IF_ID_PC4, FlushE, RegWriteW, RdW, ResultW,
        input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ResultSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );
    modport slave (
        input  IF_ID_IR, IF_ID_PC, IF_ID_PC4, FlushE, RegWriteW, RdW, ResultW,
        output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ResultSrcE,
               ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/instruction_decode.sv
// instruction_decode: RV32I decode stage with register file, immediate generation and ID/EX register
module instruction_decode (
    input logic                 clk,
    input logic                 rst,
    instruction_decode_if.slave id_if
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10;
    typedef struct packed {
        logic       reg_write, mem_write, branch, jump, jalr, alu_src;
        logic [1:0] result_src;
        logic [3:0] alu_ctl;
    } ctl_t;
    typedef struct packed {
        ctl_t        ctl;
        logic [2:0]  funct3;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } idex_t;
    logic [31:0] ir;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2, imm_i, imm_s, imm_b, imm_j, imm_u, imm;
    logic [31:0] rf_q [32];
    ctl_t        ctl;
    idex_t       idex_d, idex_q;
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    assign ir    = id_if.IF_ID_IR;
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    // Writeback in the same cycle is bypassed so decode never sees a stale operand
    assign rd1 = rs1 == 5'd0 ? 32'd0 : (id_if.RegWriteW && id_if.RdW == rs1) ? id_if.ResultW : rf_q[rs1];
    assign rd2 = rs2 == 5'd0 ? 32'd0 : (id_if.RegWriteW && id_if.RdW == rs2) ? id_if.ResultW : rf_q[rs2];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (id_if.RegWriteW && id_if.RdW != 5'd0) begin
            rf_q[id_if.RdW] <= id_if.ResultW;
        end
    end
    always_comb begin
        ctl = '0;
        imm = '0;
        case (ir[6:0])
            OP_R:    begin ctl.reg_write = 1'b1; ctl.alu_ctl = alu_fn(ir[14:12], ir[30]); end
            OP_I:    begin ctl.reg_write = 1'b1; ctl.alu_src = 1'b1; imm = imm_i;
                           ctl.alu_ctl = alu_fn(ir[14:12], ir[14:12] == 3'b101 && ir[30]); end
            OP_L:    begin ctl.reg_write = 1'b1; ctl.alu_src = 1'b1; ctl.result_src = 2'b01; imm = imm_i; end
            OP_S:    begin ctl.mem_write = 1'b1; ctl.alu_src = 1'b1; imm = imm_s; end
            OP_B:    begin ctl.branch = 1'b1; ctl.alu_ctl = ALU_SUB; imm = imm_b; end
            OP_JAL:  begin ctl.reg_write = 1'b1; ctl.jump = 1'b1; ctl.result_src = 2'b10; imm = imm_j; end
            OP_JALR: begin ctl.reg_write = 1'b1; ctl.jalr = 1'b1; ctl.alu_src = 1'b1;
                           ctl.result_src = 2'b10; imm = imm_i; end
            OP_LUI:  begin ctl.reg_write = 1'b1; ctl.alu_src = 1'b1; ctl.alu_ctl = ALU_PASSB; imm = imm_u; end
            default: ;
        endcase
    end
    // A flush turns the slot into a bubble: no controls and no register indices for hazard logic
    always_comb begin
        idex_d        = '0;
        idex_d.ctl    = id_if.FlushE ? '0 : ctl;
        idex_d.funct3 = ir[14:12];
        idex_d.rd1    = rd1;
        idex_d.rd2    = rd2;
        idex_d.imm    = imm;
        idex_d.pc     = id_if.IF_ID_PC;
        idex_d.pc4    = id_if.IF_ID_PC4;
        idex_d.rs1    = id_if.FlushE ? 5'd0 : rs1;
        idex_d.rs2    = id_if.FlushE ? 5'd0 : rs2;
        idex_d.rd     = id_if.FlushE ? 5'd0 : ir[11:7];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end
    assign id_if.RegWriteE   = idex_q.ctl.reg_write;
    assign id_if.MemWriteE   = idex_q.ctl.mem_write;
    assign id_if.BranchE     = idex_q.ctl.branch;
    assign id_if.JumpE       = idex_q.ctl.jump;
    assign id_if.JalrE       = idex_q.ctl.jalr;
    assign id_if.ALUSrcE     = idex_q.ctl.alu_src;
    assign id_if.ResultSrcE  = idex_q.ctl.result_src;
    assign id_if.ALUControlE = idex_q.ctl.alu_ctl;
    assign id_if.Funct3E     = idex_q.funct3;
    assign id_if.RD1E        = idex_q.rd1;
    assign id_if.RD2E        = idex_q.rd2;
    assign id_if.ImmExtE     = idex_q.imm;
    assign id_if.PCE         = idex_q.pc;
    assign id_if.PCPlus4E    = idex_q.pc4;
    assign id_if.Rs1E        = idex_q.rs1;
    assign id_if.Rs2E        = idex_q.rs2;
    assign id_if.RdE         = idex_q.rd;
endmodule
